// File: rtl/clk_ratio_ctrl.sv
// Programming front-end for the MPU clock divider: handshake in, clamped ratio strobe out, settle wait, done pulse.
// Optional `define CLK_RATIO_RAMP_EN walks the ratio one step per strobe instead of jumping straight to target.
module clk_ratio_ctrl #(
  parameter int NOB        = 4,
  parameter int SETTLE_CYC = 16,
  parameter int MIN_RATIO  = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  input  logic [NOB-1:0] req_ratio,
  output logic           req_ready,
  output logic           ratio_setting,
  output logic [NOB-1:0] divide_ratio,
  output logic [NOB-1:0] cur_ratio,
  output logic           busy,
  output logic           done,
  output logic           clamped
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] APPLY  = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;

  localparam logic [NOB-1:0]   MIN_R    = NOB'(MIN_RATIO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [NOB-1:0]   target;
  logic             clamp_flag;

  logic [NOB-1:0]   req_target;
  logic             req_clamped;
  logic [NOB-1:0]   acc_step;
  logic [NOB-1:0]   run_step;

  function automatic logic [NOB-1:0] clamp_ratio(input logic [NOB-1:0] r);
    return (r < MIN_R) ? MIN_R : r;
  endfunction

`ifdef CLK_RATIO_RAMP_EN
  function automatic logic [NOB-1:0] ramp_step(input logic [NOB-1:0] cur,
                                               input logic [NOB-1:0] tgt);
    if (tgt > cur)      return cur + NOB'(1);
    else if (tgt < cur) return cur - NOB'(1);
    else                return cur;
  endfunction
`endif

  always_comb begin
    req_target  = clamp_ratio(req_ratio);
    req_clamped = (req_ratio < MIN_R);
`ifdef CLK_RATIO_RAMP_EN
    acc_step    = ramp_step(cur_ratio, req_target);
    run_step    = ramp_step(cur_ratio, target);
`else
    acc_step    = req_target;
    run_step    = target;
`endif
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Strobe is registered on the edge that enters APPLY, so it is visible for the whole APPLY cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      target        <= '0;
      clamp_flag    <= 1'b0;
      ratio_setting <= 1'b0;
      divide_ratio  <= '0;
      cur_ratio     <= '0;
      done          <= 1'b0;
      clamped       <= 1'b0;
    end else begin
      ratio_setting <= 1'b0;
      done          <= 1'b0;
      clamped       <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_target == cur_ratio) begin
              done    <= 1'b1;
              clamped <= req_clamped;
            end else begin
              state         <= APPLY;
              target        <= req_target;
              clamp_flag    <= req_clamped;
              ratio_setting <= 1'b1;
              divide_ratio  <= acc_step;
              cur_ratio     <= acc_step;
            end
          end
        end
        APPLY: begin
          state <= SETTLE;
          cnt   <= '0;
        end
        SETTLE: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            if (cur_ratio == target) begin
              state   <= IDLE;
              done    <= 1'b1;
              clamped <= clamp_flag;
            end else begin
              state         <= APPLY;
              ratio_setting <= 1'b1;
              divide_ratio  <= run_step;
              cur_ratio     <= run_step;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_ratio_ctrl.sv
// Bench for clk_ratio_ctrl: request table with queued strobe/done expectations plus reset-mid-operation sequence.
// Expectations follow the ramp behaviour when CLK_RATIO_RAMP_EN is defined.
module tb_clk_ratio_ctrl;
  localparam int NOB        = 4;
  localparam int SETTLE_CYC = 4;
  localparam int MIN_RATIO  = 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           req_valid;
  logic [NOB-1:0] req_ratio;
  logic           req_ready;
  logic           ratio_setting;
  logic [NOB-1:0] divide_ratio;
  logic [NOB-1:0] cur_ratio;
  logic           busy;
  logic           done;
  logic           clamped;

  clk_ratio_ctrl #(.NOB(NOB), .SETTLE_CYC(SETTLE_CYC), .MIN_RATIO(MIN_RATIO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ratio(req_ratio),
    .req_ready(req_ready), .ratio_setting(ratio_setting), .divide_ratio(divide_ratio),
    .cur_ratio(cur_ratio), .busy(busy), .done(done), .clamped(clamped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [NOB-1:0] val; } strb_t;
  typedef struct { int cyc; logic [NOB-1:0] cur; logic cl; } done_t;
  typedef struct { logic [NOB-1:0] ratio; logic [NOB-1:0] exp_cur; } vec_t;

  strb_t strobe_q[$];
  done_t done_q[$];
  strb_t ms;
  done_t md;
  logic [NOB-1:0] model_cur;
  vec_t vecs[9];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ratio_setting"}, ratio_setting, 0);
    chk({tag, "_divide_ratio"}, divide_ratio, 0);
    chk({tag, "_cur_ratio"}, cur_ratio, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_clamped"}, clamped, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
  endtask

  // Reference model: expand one request into its strobe sequence and final done event
  task automatic push_req(input logic [NOB-1:0] r, input int e0);
    logic [NOB-1:0] tgt;
    logic [NOB-1:0] c;
    logic           cl;
    int             n;
    cl  = (r < NOB'(MIN_RATIO));
    tgt = cl ? NOB'(MIN_RATIO) : r;
    c   = model_cur;
    n   = 0;
    while (c != tgt) begin
`ifdef CLK_RATIO_RAMP_EN
      c = (tgt > c) ? c + 1'b1 : c - 1'b1;
`else
      c = tgt;
`endif
      strobe_q.push_back('{cyc: e0 + n * (SETTLE_CYC + 1), val: c});
      n++;
    end
    done_q.push_back('{cyc: e0 + n * (SETTLE_CYC + 1), cur: tgt, cl: cl});
    model_cur = tgt;
  endtask

  task automatic do_req(input logic [NOB-1:0] r, input logic [NOB-1:0] exp_cur);
    int waited;
    chk("ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    req_ratio = r;
    push_req(r, cyc + 1);
    @(posedge clk);
    waited = 0;
    forever begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      if (done_q.size() == 0) break;
      waited++;
      if (waited > 300) begin
        chk("done_timeout", 1, 0);
        done_q.delete();
        break;
      end
    end
    chk("missing_strobes", strobe_q.size(), 0);
    strobe_q.delete();
    chk("final_cur_ratio", cur_ratio, exp_cur);
    chk("final_divide_ratio", divide_ratio, exp_cur);
    chk("final_busy", busy, 0);
    chk("final_ready", req_ready, 1);
  endtask

  initial begin
    vecs[0] = '{ratio: 4'd6,  exp_cur: 4'd6};
    vecs[1] = '{ratio: 4'd0,  exp_cur: 4'd1};
    vecs[2] = '{ratio: 4'd6,  exp_cur: 4'd6};
    vecs[3] = '{ratio: 4'd6,  exp_cur: 4'd6};
    vecs[4] = '{ratio: 4'd3,  exp_cur: 4'd3};
    vecs[5] = '{ratio: 4'd15, exp_cur: 4'd15};
    vecs[6] = '{ratio: 4'd1,  exp_cur: 4'd1};
    vecs[7] = '{ratio: 4'd1,  exp_cur: 4'd1};
    vecs[8] = '{ratio: 4'd0,  exp_cur: 4'd1};

    model_cur = '0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_ratio = '0;

    fork
      forever begin
        @(negedge clk);
        if (ratio_setting === 1'b1) begin
          if (strobe_q.size() == 0) chk("unexpected_strobe", 1, 0);
          else begin
            ms = strobe_q.pop_front();
            chk("strobe_cycle", cyc, ms.cyc);
            chk("strobe_ratio", divide_ratio, ms.val);
          end
        end
        if (done === 1'b1) begin
          if (done_q.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            md = done_q.pop_front();
            chk("done_cycle", cyc, md.cyc);
            chk("done_cur_ratio", cur_ratio, md.cur);
            chk("done_clamped", clamped, md.cl);
          end
        end else if (clamped === 1'b1) begin
          chk("clamped_without_done", 1, 0);
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("in_reset");
    reset = 1'b0;
    @(negedge clk);
    chk_reset_state("after_reset");

    for (int i = 0; i < 9; i++) do_req(vecs[i].ratio, vecs[i].exp_cur);

    // Reset during SETTLE with a new request held on the bus
    req_valid = 1'b1;
    req_ratio = 4'd9;
    push_req(4'd9, cyc + 1);
    @(posedge clk);
    @(negedge clk);
    req_ratio = 4'd2;
    @(negedge clk);
    #1;
    chk("busy_while_settle", busy, 1);
    chk("ready_while_settle", req_ready, 0);
`ifdef CLK_RATIO_RAMP_EN
    chk("held_divide_ratio", divide_ratio, 2);
`else
    chk("held_divide_ratio", divide_ratio, 9);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_state("mid_op_reset");
    strobe_q.delete();
    done_q.delete();
    model_cur = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    do_req(4'd2, 4'd2);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected 0", 1);
    $fatal(1, "timeout");
  end
endmodule
